// File: rtl/pzbcm_sram_mp_pkg.sv
// rtl/pzbcm_sram_mp_pkg.sv - shared width helpers and parameter bundle for the multi-port banked SRAM
// Purpose: derives address, bank-select and row widths from the geometry parameters.
// Ports: none (package).
package pzbcm_sram_mp_pkg;

  typedef struct packed {
    int channels;
    int banks;
    int data_width;
    int words;
    int read_latency;
  } pzbcm_sram_mp_params;

  function automatic int get_address_width(input int words, input int banks);
    return $clog2(words * banks);
  endfunction

  // A single bank still gets a 1-bit select field so vectors never collapse to zero width.
  function automatic int get_bank_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  function automatic int get_row_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/pzbcm_sram_mp_rr_arbiter.sv
// rtl/pzbcm_sram_mp_rr_arbiter.sv - per-bank round-robin arbiter with one-hot grant
// Purpose: picks the first requester at or after the rotating pointer.
// Ports:
//   i_clk, i_rst, i_clear : clock, sync active-high reset, sync flush of the pointer
//   i_request             : per-channel request vector (already qualified by the caller)
//   o_grant               : one-hot grant, combinational from i_request and the pointer
module pzbcm_sram_mp_rr_arbiter
  import pzbcm_sram_mp_pkg::*;
#(
  parameter int CHANNELS = 2
)(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic [CHANNELS-1:0] i_request,
  output logic [CHANNELS-1:0] o_grant
);

  localparam int PTR_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PTR_WIDTH-1:0] rr_ptr;
  logic [PTR_WIDTH-1:0] next_ptr;
  logic                 found;

  // Outer loop walks priority order starting at rr_ptr; inner loop matches the
  // rotated position to a concrete channel so every index stays a loop constant.
  always_comb begin
    o_grant  = '0;
    next_ptr = rr_ptr;
    found    = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      for (int j = 0; j < CHANNELS; j++) begin
        if (!found && i_request[j] && (j == ((int'(rr_ptr) + i) % CHANNELS))) begin
          found      = 1'b1;
          o_grant[j] = 1'b1;
          next_ptr   = PTR_WIDTH'((j + 1) % CHANNELS);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/pzbcm_sram_mp.sv
// rtl/pzbcm_sram_mp.sv - multi-channel banked 1RW SRAM with per-bank round-robin and credit-gated reads
// Purpose: CHANNELS requesters share BANKS single-port banks; each channel owns a
//          first-word-fall-through response FIFO sized so reads can never overflow it.
// Ports:
//   i_clk, i_rst      : clock, sync active-high reset
//   i_clear           : sync flush of in-flight reads, FIFOs, credits and arbiters (memory kept)
//   i_req_*           : per-channel request (valid, write, word address, data, byte strobe)
//   o_req_ready       : per-channel grant this cycle
//   o_rsp_valid/data  : per-channel response FIFO head; i_rsp_ready pops it
//   o_busy            : any read in flight or any FIFO non-empty
module pzbcm_sram_mp
  import pzbcm_sram_mp_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int BANKS        = 2,
  parameter int BANK_LSB     = 1,
  parameter int DATA_WIDTH   = 32,
  parameter int WORDS        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2,
  localparam int ADDRESS_WIDTH = get_address_width(WORDS, BANKS)
)(
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_clear,
  input  logic [CHANNELS-1:0]                      i_req_valid,
  output logic [CHANNELS-1:0]                      o_req_ready,
  input  logic [CHANNELS-1:0]                      i_req_write,
  input  logic [CHANNELS-1:0][ADDRESS_WIDTH-1:0]   i_req_address,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]      i_req_data,
  input  logic [CHANNELS-1:0][DATA_WIDTH/8-1:0]    i_req_strobe,
  output logic [CHANNELS-1:0]                      o_rsp_valid,
  input  logic [CHANNELS-1:0]                      i_rsp_ready,
  output logic [CHANNELS-1:0][DATA_WIDTH-1:0]      o_rsp_data,
  output logic                                     o_busy
);

  localparam int BANK_WIDTH     = get_bank_width(BANKS);
  localparam int ROW_WIDTH      = get_row_width(WORDS);
  localparam int STROBE_WIDTH   = DATA_WIDTH / 8;
  localparam int CHANNEL_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CREDIT_WIDTH   = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic                                   flush;
  logic [CHANNELS-1:0][BANK_WIDTH-1:0]    req_bank;
  logic [CHANNELS-1:0][ROW_WIDTH-1:0]     req_row;
  logic [CHANNELS-1:0]                    credit_ok;
  logic [CHANNELS-1:0]                    eligible;
  logic [BANKS-1:0][CHANNELS-1:0]         bank_request;
  logic [BANKS-1:0][CHANNELS-1:0]         bank_grant;
  logic [CHANNELS-1:0]                    granted;
  logic [BANKS-1:0]                       push_valid;
  logic [BANKS-1:0][CHANNEL_WIDTH-1:0]    push_channel;
  logic [BANKS-1:0][DATA_WIDTH-1:0]       push_data;
  logic [BANKS-1:0]                       pipe_busy;
  logic [CHANNELS-1:0]                    fifo_nonempty;

  assign flush = i_rst || i_clear;

  // Address decode and eligibility. Reads need a free credit so the response
  // always has a FIFO slot by the time it emerges from the bank.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_decode
    if (BANKS == 1) begin : g_single
      assign req_bank[c] = '0;
      assign req_row[c]  = i_req_address[c][ROW_WIDTH-1:0];
    end else if (BANK_LSB != 0) begin : g_lsb
      assign req_bank[c] = i_req_address[c][BANK_WIDTH-1:0];
      assign req_row[c]  = i_req_address[c][ADDRESS_WIDTH-1:BANK_WIDTH];
    end else begin : g_msb
      assign req_bank[c] = i_req_address[c][ADDRESS_WIDTH-1:ROW_WIDTH];
      assign req_row[c]  = i_req_address[c][ROW_WIDTH-1:0];
    end
    assign eligible[c] = i_req_valid[c] && !flush && (i_req_write[c] || credit_ok[c]);
  end

  always_comb begin
    granted = '0;
    for (int b = 0; b < BANKS; b++) begin
      granted = granted | bank_grant[b];
    end
  end

  assign o_req_ready = granted;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0]                          mem [WORDS];
    logic [ROW_WIDTH-1:0]                           sel_row;
    logic [DATA_WIDTH-1:0]                          sel_data;
    logic [STROBE_WIDTH-1:0]                        sel_strobe;
    logic                                           sel_write;
    logic                                           sel_read;
    logic [CHANNEL_WIDTH-1:0]                       sel_channel;
    logic [READ_LATENCY-1:0]                        pipe_valid;
    logic [READ_LATENCY-1:0][CHANNEL_WIDTH-1:0]     pipe_channel;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0]        pipe_data;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_req
      assign bank_request[b][c] = eligible[c] && (req_bank[c] == BANK_WIDTH'(b));
    end

    pzbcm_sram_mp_rr_arbiter #(
      .CHANNELS (CHANNELS)
    ) u_arbiter (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (i_clear),
      .i_request (bank_request[b]),
      .o_grant   (bank_grant[b])
    );

    // Grant is one-hot, so this collapses to a plain mux of the winning channel.
    always_comb begin
      sel_row     = '0;
      sel_data    = '0;
      sel_strobe  = '0;
      sel_write   = 1'b0;
      sel_read    = 1'b0;
      sel_channel = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (bank_grant[b][c]) begin
          sel_row     = req_row[c];
          sel_data    = i_req_data[c];
          sel_strobe  = i_req_strobe[c];
          sel_write   = i_req_write[c];
          sel_read    = !i_req_write[c];
          sel_channel = CHANNEL_WIDTH'(c);
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (sel_write) begin
        for (int i = 0; i < STROBE_WIDTH; i++) begin
          if (sel_strobe[i]) begin
            mem[sel_row][8*i +: 8] <= sel_data[8*i +: 8];
          end
        end
      end
      if (sel_read) begin
        pipe_data[0] <= mem[sel_row];
      end
      pipe_channel[0] <= sel_channel;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_data[k]    <= pipe_data[k-1];
        pipe_channel[k] <= pipe_channel[k-1];
      end
    end

    // Only the valid bits need flushing; data/channel are qualified by them.
    always_ff @(posedge i_clk) begin
      if (flush) begin
        pipe_valid <= '0;
      end else begin
        pipe_valid[0] <= sel_read;
        for (int k = 1; k < READ_LATENCY; k++) begin
          pipe_valid[k] <= pipe_valid[k-1];
        end
      end
    end

    assign push_valid[b]   = pipe_valid[READ_LATENCY-1];
    assign push_channel[b] = pipe_channel[READ_LATENCY-1];
    assign push_data[b]    = pipe_data[READ_LATENCY-1];
    assign pipe_busy[b]    = |pipe_valid;
  end

  // All banks share one latency and a channel is granted at most once per cycle,
  // so at most one bank pushes into a given channel's FIFO in any cycle.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
    logic [DATA_WIDTH-1:0]     storage [FIFO_DEPTH];
    logic [FIFO_PTR_WIDTH-1:0] wr_ptr;
    logic [FIFO_PTR_WIDTH-1:0] rd_ptr;
    logic [CREDIT_WIDTH-1:0]   count;
    logic [CREDIT_WIDTH-1:0]   credit;
    logic                      push;
    logic                      pop;
    logic                      read_grant;
    logic [DATA_WIDTH-1:0]     push_word;

    always_comb begin
      push      = 1'b0;
      push_word = '0;
      for (int b = 0; b < BANKS; b++) begin
        if (push_valid[b] && (push_channel[b] == CHANNEL_WIDTH'(c))) begin
          push      = 1'b1;
          push_word = push_data[b];
        end
      end
    end

    assign pop        = o_rsp_valid[c] && i_rsp_ready[c];
    assign read_grant = granted[c] && !i_req_write[c];

    always_ff @(posedge i_clk) begin
      if (push) begin
        storage[wr_ptr] <= push_word;
      end
    end

    always_ff @(posedge i_clk) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        credit <= '0;
      end else begin
        if (push) begin
          wr_ptr <= (wr_ptr == FIFO_PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == FIFO_PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
        count  <= count + CREDIT_WIDTH'(push) - CREDIT_WIDTH'(pop);
        credit <= credit + CREDIT_WIDTH'(read_grant) - CREDIT_WIDTH'(pop);
      end
    end

    assign fifo_nonempty[c] = (count != '0);
    assign o_rsp_valid[c]   = fifo_nonempty[c] && !flush;
    assign o_rsp_data[c]    = storage[rd_ptr];
    assign credit_ok[c]     = (credit < CREDIT_WIDTH'(FIFO_DEPTH));
  end

  assign o_busy = !flush && ((|pipe_busy) || (|fifo_nonempty));

endmodule

// File: tb/tb_pzbcm_sram_mp.sv
// tb/tb_pzbcm_sram_mp.sv - scoreboard bench for the multi-port banked SRAM
module tb_pzbcm_sram_mp;

  localparam int CH = 2;
  localparam int BK = 2;
  localparam int DW = 32;
  localparam int WD = 16;
  localparam int RL = 2;
  localparam int FD = 3;
  localparam int AW = 5;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic [CH-1:0]         req_valid;
  logic [CH-1:0]         req_ready;
  logic [CH-1:0]         req_write;
  logic [CH-1:0][AW-1:0] req_addr;
  logic [CH-1:0][DW-1:0] req_data;
  logic [CH-1:0][SW-1:0] req_strb;
  logic [CH-1:0]         rsp_valid;
  logic [CH-1:0]         rsp_ready;
  logic [CH-1:0][DW-1:0] rsp_data;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  bit done;

  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_q [CH][$];

  always #5 clk = ~clk;

  pzbcm_sram_mp #(
    .CHANNELS     (CH),
    .BANKS        (BK),
    .BANK_LSB     (1),
    .DATA_WIDTH   (DW),
    .WORDS        (WD),
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_clear       (clr),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_write   (req_write),
    .i_req_address (req_addr),
    .i_req_data    (req_data),
    .i_req_strobe  (req_strb),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_data    (rsp_data),
    .o_busy        (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: flat word-addressed memory; a granted read captures the
  // current contents as the expected response for that channel.
  always @(negedge clk) begin
    if (rst || clr) begin
      for (int c = 0; c < CH; c++) exp_q[c].delete();
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (req_valid[c] && req_ready[c] && !req_write[c])
          exp_q[c].push_back(ref_mem[req_addr[c]]);
      end
      for (int c = 0; c < CH; c++) begin
        if (req_valid[c] && req_ready[c] && req_write[c]) begin
          for (int i = 0; i < SW; i++) begin
            if (req_strb[c][i]) ref_mem[req_addr[c]][8*i +: 8] <= req_data[c][8*i +: 8];
          end
        end
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (rsp_valid[c] && rsp_ready[c]) begin
        if (exp_q[c].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected ch%0d: got %h expected no response", c, rsp_data[c]);
        end else begin
          check($sformatf("rsp_data_ch%0d", c), rsp_data[c], exp_q[c].pop_front());
        end
      end
    end
  end

  task automatic wait_grant(input int c, output bit got);
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = req_ready[c];
      if (!got) begin
        @(posedge clk);
        #1;
      end
    end
    check("grant_wait", got, 1);
  endtask

  task automatic issue(input int c, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    bit got;
    req_write[c] = wr;
    req_addr[c]  = a;
    req_data[c]  = d;
    req_strb[c]  = s;
    req_valid[c] = 1'b1;
    wait_grant(c, got);
    @(posedge clk);
    #1;
    req_valid[c] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    check("drain_idle", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic count_grants(input int c, input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      cnt += int'(req_ready[c]);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [AW-1:0] rand_even();
    return AW'($urandom_range(0, 15) * 2);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit got;
    int cnt;
    logic [CH-1:0] g;
    logic [CH-1:0] prev;

    rst = 1'b1; clr = 1'b0;
    req_valid = '1; req_write = '0; req_addr = '0; req_data = '0; req_strb = '0;
    rsp_ready = '1;
    prev = '0;
    repeat (3) begin
      @(negedge clk);
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;

    for (int a = 0; a < 32; a++) issue(0, 1'b1, AW'(a), $urandom, '1);

    // Byte strobes and exact read latency
    issue(0, 1'b1, 5'd4, 32'hAABBCCDD, 4'hF);
    issue(0, 1'b1, 5'd4, 32'h11223344, 4'b0101);
    req_write[0] = 1'b0; req_addr[0] = 5'd4; req_valid[0] = 1'b1;
    wait_grant(0, got);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("lat_valid_g1", rsp_valid[0], 0);
    check("busy_inflight", busy, 1);
    @(negedge clk);
    check("lat_valid_g2", rsp_valid[0], 0);
    @(negedge clk);
    check("lat_valid_g3", rsp_valid[0], 1);
    check("strobe_data", rsp_data[0], 32'hAA22CC44);
    @(posedge clk); #1;
    issue(0, 1'b1, 5'd4, 32'hDEADBEEF, 4'h0);
    issue(0, 1'b0, 5'd4, '0, '0);
    wait_idle();

    // Round-robin on one bank
    req_write = '0;
    req_addr[0] = rand_even();
    req_addr[1] = rand_even();
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      g = req_ready;
      check("rr_one_grant", $countones(g), 1);
      if (k > 0) check("rr_alternate", g, {prev[0], prev[1]});
      prev = g;
      @(posedge clk); #1;
      if (g[0]) req_addr[0] = rand_even();
      if (g[1]) req_addr[1] = rand_even();
    end
    req_valid = '0;
    wait_idle();

    // Different banks proceed in parallel
    req_write = '1; req_strb = '1; req_addr[0] = 5'd2; req_addr[1] = 5'd3; req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      req_data[0] = $urandom;
      req_data[1] = $urandom;
      @(negedge clk);
      check("bank_parallel_write", req_ready, 2'b11);
      @(posedge clk); #1;
    end
    req_write = '0;
    @(negedge clk);
    check("bank_parallel_read", req_ready, 2'b11);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Credit backpressure
    req_write[0] = 1'b0; req_addr[0] = 5'd8; rsp_ready[0] = 1'b0; req_valid[0] = 1'b1;
    count_grants(0, 8, cnt);
    check("credit_grants", cnt, FD);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("credit_blocked", req_ready[0], 0);
    check("credit_rsp_avail", rsp_valid[0], 1);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    count_grants(0, 6, cnt);
    check("credit_one_more", cnt, 1);
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    wait_idle();

    // Clear with a read in flight
    issue(1, 1'b1, 5'd6, $urandom, 4'hF);
    req_write[0] = 1'b0; req_addr[0] = 5'd6; req_valid[0] = 1'b1;
    wait_grant(0, got);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cnt += int'(rsp_valid[0]);
      @(posedge clk); #1;
    end
    check("clear_no_response", cnt, 0);
    @(negedge clk);
    check("clear_idle", busy, 0);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0; req_valid[0] = 1'b1;
    count_grants(0, 8, cnt);
    check("clear_credit_reset", cnt, FD);
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    wait_idle();

    // Randomized traffic; ch1 reads 0..15 in order first
    done = 1'b0;
    fork
      begin
        fork
          begin
            repeat (60) issue(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom, SW'($urandom));
          end
          begin
            for (int i = 0; i < 16; i++) issue(1, 1'b0, AW'(i), '0, '0);
            repeat (20) issue(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom, SW'($urandom));
          end
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          rsp_ready = CH'($urandom_range(0, 3));
          @(posedge clk); #1;
        end
      end
    join
    rsp_ready = '1;
    wait_idle();
    for (int c = 0; c < CH; c++) check($sformatf("queue_empty_ch%0d", c), exp_q[c].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pzbcm_sram_mp.md
Name: pzbcm_sram_mp

Overview:
- Multi-channel, banked, single-port SRAM block.
- CHANNELS independent requesters share BANKS 1RW banks. Each bank has its own round-robin arbiter; the design supports byte-strobed writes and per-channel credit-gated reads.
- Each channel has its own first-word-fall-through response FIFO.
- Sits between several engines (DMA, cache fill, descriptor fetch) and shared local storage.

Parameters:
- CHANNELS, 2, number of requester channels (1..8).
- BANKS, 2, number of banks; power of two.
- BANK_LSB, 1, 1: bank taken from address LSBs; 0: from MSBs.
- DATA_WIDTH, 32, word width; multiple of 8.
- WORDS, 1024, words per bank; power of two.
- READ_LATENCY, 1, bank read latency in cycles (>=1).
- FIFO_DEPTH, READ_LATENCY+2, response FIFO entries per channel.
- ADDRESS_WIDTH, $clog2(WORDS*BANKS), derived; not overridable.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_clear  in  1  sync flush of in-flight reads, FIFOs and arbiter state
- i_req_valid  in  CHANNELS  request valid per channel
- o_req_ready  out  CHANNELS  request accepted this cycle (grant)
- i_req_write  in  CHANNELS  1 = write, 0 = read
- i_req_address  in  CHANNELS x ADDRESS_WIDTH  word address
- i_req_data  in  CHANNELS x DATA_WIDTH  write data
- i_req_strobe  in  CHANNELS x DATA_WIDTH/8  write byte enables
- o_rsp_valid  out  CHANNELS  response FIFO non-empty
- i_rsp_ready  in  CHANNELS  pop response
- o_rsp_data  out  CHANNELS x DATA_WIDTH  read data, FIFO head
- o_busy  out  1  any read in flight or any FIFO non-empty

Behaviour:
- Interface: one clock; reset is synchronous and active-high (i_clk, i_rst).
- Reset and clear:
  - While i_rst=1 (sampled at a clock edge): all RR pointers go to 0, credits to 0, read pipelines and FIFOs empty.
  - o_req_ready=0, o_rsp_valid=0, o_busy=0. o_rsp_data is don't-care while valid=0.
  - i_clear does the same, except memory contents are kept.
  - No request is accepted in a cycle where i_rst or i_clear is 1.
- Bank decode:
  - BANK_LSB=1: bank = address[log2(BANKS)-1:0], row = the upper bits.
  - BANK_LSB=0: the reverse.
  - BANKS=1: bank is always 0.
- Eligibility:
  - A write is eligible whenever valid.
  - A read is eligible only if credit[c] < FIFO_DEPTH, where credit[c] = reads in flight + FIFO occupancy.
- Arbitration:
  - Per bank, round-robin among eligible channels targeting that bank. Search starts at rr_ptr[b].
  - On a grant to channel g, rr_ptr[b] <= (g+1) mod CHANNELS. With no grant, the pointer holds.
  - Each channel targets one bank, so it receives at most one grant per cycle. o_req_ready[c] = granted[c], combinational from the request inputs.
  - Non-granted requests must be held stable by the requester (valid/ready handshake).
- Write:
  - Each byte i with strobe[i]=1 is written at the granted cycle's edge; other bytes are unchanged.
  - A strobe of all zeros still consumes the grant but changes nothing.
- Read:
  - Data is pushed into FIFO[c] exactly READ_LATENCY cycles after the grant.
  - o_rsp_valid can rise at the earliest READ_LATENCY+1 cycles after the grant edge when the FIFO is empty.
  - A read of an address written in an earlier cycle returns the new data.
- Credit:
  - Increments on a read grant, decrements on a pop (o_rsp_valid && i_rsp_ready). Both in one cycle leaves it unchanged.
  - Credit never exceeds FIFO_DEPTH, so the FIFO can never overflow.
  - i_rsp_ready while empty is ignored.
- Ordering: responses per channel are in request order. There is no cross-channel ordering.
- Simultaneous access: two channels hitting the same bank in one cycle get one grant; two channels on different banks both get granted.

Decomposition:
- Package pzbcm_sram_mp_pkg holds:
  - Functions get_address_width, get_bank_width, get_row_width.
  - Typedef pzbcm_sram_mp_params (channels, banks, data_width, words, read_latency).
- Sub-module pzbcm_sram_mp_rr_arbiter: CHANNELS-wide request vector in, one-hot grant out, pointer register with i_rst/i_clear. One instance per bank.
- Banks and response FIFOs are inline generate loops.

Test Plan:
- Reset: hold i_rst 3 cycles with all valids 1 -> o_req_ready=0, o_rsp_valid=0, o_busy=0 throughout.
- Byte strobe: ch0 writes 0xAABBCCDD to addr 4, then 0x11223344 with strobe 0b0101, then reads addr 4 -> response 0xAA22CC44 exactly READ_LATENCY+1 cycles after the read grant.
- Round-robin (BANKS=2, BANK_LSB=1): ch0 and ch1 read even addresses continuously -> grants alternate ch0, ch1, ch0, ch1. Ch0 on addr 2 with ch1 on addr 3 -> both granted every cycle.
- Credit backpressure: FIFO_DEPTH=3, i_rsp_ready[0]=0, ch0 issues reads -> exactly 3 grants, then o_req_ready[0]=0. One pop -> exactly one more grant.
- Clear mid-flight: READ_LATENCY=2, assert i_clear the cycle after a read grant -> no response ever appears and credit returns to 0. A write made before the clear remains readable.
- In-order check: ch1 reads addrs 0..15 with random i_rsp_ready against a scoreboard -> data returned in order, no loss or duplication.
